stage_mem_ooo: RTL and testbench

- Parametrised successor memory stage. Sits between execute and write stages.
- Decouples the request and response phases of the data bus, allowing up to DEPTH instructions in flight with in-order retirement.
- Does byte-lane alignment, store byte enables, load shift/extension and misalignment detection itself; the bus sees only aligned XLEN-wide words.

---
 rtl/stage_mem_ooo.sv | 120 ++++++++++++
 tb/tb_stage_mem_ooo.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_mem_ooo.sv
// stage_mem_ooo: decoupled memory stage with up to DEPTH instructions in flight and in-order retirement.
module stage_mem_ooo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic [XLEN-1:0]   mem_pc,
  input  logic [XLEN-1:0]   mem_data0,
  input  logic [XLEN-1:0]   mem_data1,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_extend,
  input  logic [1:0]        mem_width,
  input  logic [4:0]        wb_reg,
  input  logic              wb_stall,
  output logic              req,
  input  logic              req_ready,
  output logic [XLEN-1:0]   addr,
  output logic              write,
  output logic [XLEN-1:0]   data_out,
  output logic [XLEN/8-1:0] byte_en,
  input  logic              resp_valid,
  input  logic [XLEN-1:0]   resp_data,
  output logic              mem_stall,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_pc,
  output logic [4:0]        wb_reg_r,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_misaligned
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [XLEN-1:0] d0;
    logic            ld;
    logic            mis;
    logic [1:0]      wid;
    logic            ext;
    logic [OW-1:0]   off;
  } ent_t;

  ent_t            ent_q [DEPTH];
  ent_t            ent_d, head;
  logic [XLEN-1:0] resp_q [DEPTH];
  logic [AW-1:0]   hd_q, hd_d, tl_q, tl_d, rh_q, rh_d, rt_q, rt_d;
  logic [AW:0]     cnt_q, cnt_d, rcnt_q, rcnt_d;
  logic            memop, mis, full, accept, pop, rpop, s;
  logic [2:0]      a3;
  logic [7:0]      m;
  logic [XLEN-1:0] sh, keep, ld_data;

  always_comb begin
    memop = mem_read | mem_write;
    a3 = mem_data0[2:0];
    mis = memop & (mem_width == 2'd1 ? a3[0] :
                   mem_width == 2'd2 ? |a3[1:0] :
                   mem_width == 2'd3 ? (XLEN == 32) | (|a3) : 1'b0);
    full = cnt_q == (AW+1)'(DEPTH);
    accept = mem_valid & ~full & (~memop | mis | req_ready);
    req = mem_valid & memop & ~mis & ~full;
    mem_stall = mem_valid & ~accept;
    m = mem_width == 2'd0 ? 8'h01 : mem_width == 2'd1 ? 8'h03 : mem_width == 2'd2 ? 8'h0F : 8'hFF;
    addr = req ? {mem_data0[XLEN-1:OW], OW'(0)} : '0;
    write = req & mem_write;
    data_out = req ? mem_data1 << {mem_data0[OW-1:0], 3'b000} : '0;
    byte_en = req ? NB'(m) << mem_data0[OW-1:0] : '0;
    ent_d = '{pc: mem_pc, rd: wb_reg, d0: mem_data0, ld: mem_read, mis: mis,
              wid: mem_width, ext: mem_extend, off: mem_data0[OW-1:0]};
    head = ent_q[hd_q];
    wb_valid = (cnt_q != '0) & (~head.ld | head.mis | (rcnt_q != '0));
    pop = wb_valid & ~wb_stall;
    rpop = pop & head.ld & ~head.mis;
    // keep ^ (keep >> 1) isolates the top bit of the loaded field, i.e. its sign bit
    sh = resp_q[rh_q] >> {head.off, 3'b000};
    keep = head.wid == 2'd0 ? XLEN'(8'hFF) : head.wid == 2'd1 ? XLEN'(16'hFFFF) :
           head.wid == 2'd2 ? XLEN'(32'hFFFF_FFFF) : '1;
    s = head.ext & (|(sh & (keep ^ (keep >> 1))));
    ld_data = (sh & keep) | (s ? ~keep : '0);
    wb_pc = wb_valid ? head.pc : '0;
    wb_reg_r = wb_valid ? head.rd : '0;
    wb_data = ~wb_valid ? '0 : (head.ld & ~head.mis) ? ld_data : head.d0;
    wb_misaligned = wb_valid & head.mis;
    hd_d = hd_q + AW'(pop);
    tl_d = tl_q + AW'(accept);
    cnt_d = cnt_q + (AW+1)'(accept) - (AW+1)'(pop);
    rh_d = rh_q + AW'(rpop);
    rt_d = rt_q + AW'(resp_valid);
    rcnt_d = rcnt_q + (AW+1)'(resp_valid) - (AW+1)'(rpop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hd_q <= '0;
      tl_q <= '0;
      cnt_q <= '0;
      rh_q <= '0;
      rt_q <= '0;
      rcnt_q <= '0;
    end else begin
      hd_q <= hd_d;
      tl_q <= tl_d;
      cnt_q <= cnt_d;
      rh_q <= rh_d;
      rt_q <= rt_d;
      rcnt_q <= rcnt_d;
    end
  end

  // Storage needs no reset: every read is qualified by the counters.
  always_ff @(posedge clk) begin
    if (accept) ent_q[tl_q] <= ent_d;
    if (resp_valid) resp_q[rt_q] <= resp_data;
  end
endmodule

// File: tb/tb_stage_mem_ooo.sv
// tb_stage_mem_ooo: directed and random checks of stage_mem_ooo against a queue-based reference model.
module tb_stage_mem_ooo;
  logic        clk = 0, reset = 1;
  logic        mem_valid, mem_read, mem_write, mem_extend, wb_stall, req_ready, resp_valid;
  logic [31:0] mem_pc, mem_data0, mem_data1, resp_data;
  logic [1:0]  mem_width;
  logic [4:0]  wb_reg;
  logic        req, write, mem_stall, wb_valid, wb_misaligned;
  logic [31:0] addr, data_out, wb_pc, wb_data;
  logic [3:0]  byte_en;
  logic [4:0]  wb_reg_r;

  stage_mem_ooo #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_data0(mem_data0),
    .mem_data1(mem_data1), .mem_read(mem_read), .mem_write(mem_write), .mem_extend(mem_extend),
    .mem_width(mem_width), .wb_reg(wb_reg), .wb_stall(wb_stall), .req(req), .req_ready(req_ready),
    .addr(addr), .write(write), .data_out(data_out), .byte_en(byte_en), .resp_valid(resp_valid),
    .resp_data(resp_data), .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_reg_r(wb_reg_r), .wb_data(wb_data), .wb_misaligned(wb_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    logic        needs;
    logic        have;
    logic [1:0]  w;
    logic [1:0]  off;
    logic        ext;
  } ent_t;

  ent_t q[$];
  int   n_chk = 0, n_err = 0, outstanding = 0;
  logic accepted, got5;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld_val(input logic [31:0] raw, input logic [1:0] w,
                                         input logic [1:0] off, input logic ext);
    logic [63:0] v, mk;
    int b;
    b = 8 * (1 << w);
    mk = (64'd1 << b) - 64'd1;
    v = (64'(raw) >> (8 * off)) & mk;
    if (ext && v[b-1]) v = v | ~mk;
    return v[31:0];
  endfunction

  task automatic idle();
    mem_valid = 0; mem_read = 0; mem_write = 0; mem_extend = 0; mem_width = 0;
    mem_pc = 0; mem_data0 = 0; mem_data1 = 0; wb_reg = 0;
    wb_stall = 0; req_ready = 1; resp_valid = 0; resp_data = 0;
  endtask

  task automatic op(input logic rd, input logic wr, input logic [1:0] w, input logic ext,
                    input logic [31:0] pc, input logic [31:0] d0, input logic [31:0] d1,
                    input logic [4:0] r);
    mem_valid = 1; mem_read = rd; mem_write = wr; mem_width = w; mem_extend = ext;
    mem_pc = pc; mem_data0 = d0; mem_data1 = d1; wb_reg = r;
  endtask

  // One cycle: check outputs against the model, advance the model across the clock edge.
  task automatic step();
    logic memop, mis, full, acc, rq, hv;
    logic [1:0] off;
    ent_t e;
    #1;
    memop = mem_read | mem_write;
    off = mem_data0[1:0];
    mis = memop && (mem_width == 1 ? off[0] : mem_width == 2 ? off != 0 : mem_width == 3);
    full = q.size() == 4;
    acc = mem_valid && !full && (!memop || mis || req_ready);
    rq = mem_valid && memop && !mis && !full;
    chk("req", req, rq);
    chk("mem_stall", mem_stall, mem_valid && !acc);
    if (rq) begin
      chk("addr", addr, mem_data0 & ~32'd3);
      chk("write", write, mem_write);
      chk("byte_en", byte_en, ((1 << (1 << mem_width)) - 1) << off);
      if (mem_write) chk("data_out", data_out, 32'(mem_data1 << (8 * off)));
    end
    hv = q.size() > 0 && (!q[0].needs || q[0].have);
    chk("wb_valid", wb_valid, hv);
    if (hv) begin
      chk("wb_pc", wb_pc, q[0].pc);
      chk("wb_reg_r", wb_reg_r, q[0].rd);
      chk("wb_data", wb_data, q[0].data);
      chk("wb_misaligned", wb_misaligned, q[0].mis);
      if (!wb_stall) q.delete(0);
    end
    if (resp_valid) begin
      for (int i = 0; i < q.size(); i++)
        if (q[i].needs && !q[i].have) begin
          e = q[i];
          e.have = 1;
          e.data = ld_val(resp_data, e.w, e.off, e.ext);
          q[i] = e;
          break;
        end
      outstanding--;
    end
    if (acc) begin
      e = '{pc: mem_pc, rd: wb_reg, data: mem_data0, mis: mis, needs: mem_read && !mis,
            have: 0, w: mem_width, off: off, ext: mem_extend};
      q.push_back(e);
      if (e.needs) outstanding++;
    end
    accepted = acc;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() > 0; i++) begin
      idle();
      resp_valid = outstanding > 0;
      resp_data = $urandom;
      step();
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    idle();
    #1;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_req", req, 0);
    chk("rst_mem_stall", mem_stall, 0);
    chk("rst_wb_mis", wb_misaligned, 0);
    chk("rst_wb_data", wb_data, 0);
    repeat (2) @(negedge clk);
    reset = 0;

    op(0, 0, 0, 0, 32'h10, 32'h1234, 0, 5'd5);
    step();
    idle();
    #1;
    chk("alu_valid", wb_valid, 1);
    chk("alu_data", wb_data, 32'h1234);
    chk("alu_reg", wb_reg_r, 5);
    step();

    op(1, 0, 0, 1, 32'h20, 32'h1003, 0, 5'd7);
    #1;
    chk("lb_addr", addr, 32'h1000);
    chk("lb_be", byte_en, 4'b1000);
    step();
    idle();
    step();
    resp_valid = 1; resp_data = 32'h80FF_FFFF;
    step();
    idle();
    #1;
    chk("lb_data", wb_data, 32'hFFFF_FF80);
    step();

    op(0, 1, 1, 0, 32'h24, 32'h2002, 32'hBEEF, 0);
    #1;
    chk("sh_req", req, 1);
    chk("sh_addr", addr, 32'h2000);
    chk("sh_data", data_out, 32'hBEEF_0000);
    chk("sh_be", byte_en, 4'b1100);
    step();
    idle();
    #1;
    chk("sh_retire", wb_valid, 1);
    step();

    for (int i = 0; i < 4; i++) begin
      op(1, 0, 2, 0, 32'h100 + 4 * i, 32'h4000 + 4 * i, 0, 5'(i + 1));
      step();
    end
    op(1, 0, 2, 0, 32'h110, 32'h4010, 0, 5'd9);
    #1;
    chk("full_stall", mem_stall, 1);
    chk("full_req", req, 0);
    step();
    got5 = 0;
    for (int i = 0; i < 4; i++) begin
      resp_valid = 1; resp_data = 32'(i + 1);
      step();
      if (accepted && mem_valid) got5 = 1;
      if (got5) mem_valid = 0;
    end
    chk("fifth_accepted", got5, 1);
    drain();

    op(1, 0, 2, 0, 32'h200, 32'h3002, 0, 5'd3);
    #1;
    chk("mis_req", req, 0);
    step();
    op(0, 0, 0, 0, 32'h204, 32'h55, 0, 5'd4);
    #1;
    chk("mis_flag", wb_misaligned, 1);
    chk("mis_data", wb_data, 32'h3002);
    step();
    idle();
    #1;
    chk("after_mis_flag", wb_misaligned, 0);
    chk("after_mis_data", wb_data, 32'h55);
    step();

    op(1, 0, 2, 0, 32'h300, 32'h5000, 0, 5'd6);
    step();
    idle();
    wb_stall = 1; resp_valid = 1; resp_data = 32'hCAFE_F00D;
    step();
    resp_valid = 0;
    step();
    #1;
    chk("stall_hold_valid", wb_valid, 1);
    chk("stall_hold_data", wb_data, 32'hCAFE_F00D);
    step();
    step();
    wb_stall = 0;
    step();
    chk("stall_popped", q.size(), 0);

    for (int c = 0; c < 1500; c++) begin
      int k;
      idle();
      k = $urandom_range(0, 3);
      mem_valid = $urandom_range(0, 9) < 7;
      mem_read = k == 1 || k == 2;
      mem_write = k == 3;
      mem_width = 2'($urandom_range(0, 3));
      mem_extend = 1'($urandom);
      mem_pc = $urandom;
      mem_data0 = $urandom;
      if ($urandom_range(0, 1) == 1) mem_data0[1:0] = 0;
      mem_data1 = $urandom;
      wb_reg = 5'($urandom);
      req_ready = $urandom_range(0, 3) != 0;
      wb_stall = $urandom_range(0, 3) == 0;
      resp_valid = outstanding > 0 && $urandom_range(0, 2) != 0;
      resp_data = $urandom;
      step();
    end
    drain();

    idle();
    wb_stall = 1;
    op(0, 0, 0, 0, 32'h400, 32'h77, 0, 5'd1);
    step();
    op(1, 0, 2, 0, 32'h404, 32'h6000, 0, 5'd2);
    step();
    idle();
    wb_stall = 1;
    #1;
    chk("pre_rst_valid", wb_valid, 1);
    #1 reset = 1;
    #1;
    chk("async_rst_valid", wb_valid, 0);
    chk("async_rst_data", wb_data, 0);
    q.delete();
    outstanding = 0;
    @(negedge clk);
    reset = 0;
    wb_stall = 0;
    step();
    op(0, 0, 0, 0, 32'h500, 32'h99, 0, 5'd8);
    step();
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
